clk_div_monitor: RTL
====================

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 SHALL have parameter EXPECTED_HALF, default 4: expected divided-clock half-period in clk_hf cycles.
REQ-002 SHALL have parameter TOL, default 0: accepted deviation, +/- clk_hf cycles.
REQ-003 SHALL have parameter LOCK_COUNT, default 4: consecutive good half-periods required to lock.
REQ-004 SHALL have parameter CNT_W, default 8: width of the period counter; EXPECTED_HALF+TOL+1 < 2^CNT_W.
REQ-005 SHALL have port clk_hf, input, 1 bit: single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port clk_div_in, input, 1 bit: divided clock, sampled as asynchronous data.
REQ-008 SHALL have port enable, input, 1 bit: monitoring enable.
REQ-009 SHALL have port rise_strobe, output, 1 bit: one-cycle pulse per detected rising edge.
REQ-010 SHALL have port fall_strobe, output, 1 bit: one-cycle pulse per detected falling edge.
REQ-011 SHALL have port locked, output, 1 bit: period tracking locked.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse per bad period or timeout.
REQ-013 SHALL have port half_period, output, CNT_W bits: last measured half-period.
REQ-014 SHALL have port err_count, output, 8 bits: saturating error count.

Function
REQ-015 SHALL pass clk_div_in through a 2-flop synchronizer plus a previous-value flop; edge = sync2 XOR prev.
REQ-016 SHALL assert rise_strobe/fall_strobe for exactly one cycle, 3 clk_hf edges after the first edge sampling the new level; never both in one cycle.
REQ-017 SHALL run half_cnt: cleared to 0 in a strobe cycle, else +1, saturating at 2^CNT_W-1.
REQ-018 SHALL compute measured = half_cnt+1 in a strobe cycle and register it into half_period on every strobe when not IDLE.
REQ-019 SHALL classify a measurement good iff |measured - EXPECTED_HALF| <= TOL.
REQ-020 SHALL implement FSM states IDLE, SEARCH, TRACK, LOCKED.
REQ-021 IDLE: enable=1 -> SEARCH.
REQ-022 SEARCH: first strobe -> TRACK; good_run=0; no measurement is classified in SEARCH.
REQ-023 TRACK: good strobe -> good_run+1; reaching LOCK_COUNT -> LOCKED; bad strobe -> good_run=0, stay TRACK, err pulse.
REQ-024 LOCKED: good strobe -> stay; bad strobe -> TRACK, good_run=0, err pulse.
REQ-025 SHALL detect a timeout in TRACK or LOCKED when there is no strobe and half_cnt >= EXPECTED_HALF+TOL -> SEARCH, err pulse, good_run=0.
REQ-026 SHALL give a strobe priority over timeout in the same cycle, classifying it as a measurement.
REQ-027 SHALL drive locked=1 iff state==LOCKED, registered.
REQ-028 SHALL increment err_count on each err pulse, saturating at 255, cleared only by reset.
REQ-029 SHALL, on enable=0, go to IDLE next cycle from any state, overriding every other transition; good_run and half_cnt clear; half_period and err_count hold; strobes continue.

Reset
REQ-030 SHALL, on reset=1 at a clk_hf edge, take state IDLE and clear synchronizer flops, half_cnt, good_run, half_period and err_count to 0.
REQ-031 SHALL hold rise_strobe, fall_strobe, locked and err at 0 in the cycle after reset and for 2 further cycles.
REQ-032 SHALL give reset priority over enable and strobes; reset mid-lock drops locked the next cycle.

Structure
REQ-033 SHALL place state encodings and the default parameter constants in shared package clk_div_pkg.
REQ-034 SHALL put the synchronizer and edge detect in sub-module clk_edge_sync (in: clk_hf, reset, d; out: rise, fall).
REQ-035 SHALL keep the total RTL at 120-400 lines.

Verification
REQ-036 Reset asserted 3 cycles, clk_div_in toggling -> all outputs 0, state IDLE throughout.
REQ-037 enable=1, square wave of half-period 4 -> half_period=4 on each strobe; locked rises the cycle after the 5th strobe; err never pulses.
REQ-038 Locked, then one half-period of 5 -> single-cycle err, err_count=1, locked=0 next cycle, relock after 4 further good half-periods.
REQ-039 Locked, clk_div_in stuck high -> err the cycle half_cnt reaches 4, state SEARCH, locked=0, err_count +1.
REQ-040 enable dropped in TRACK with good_run=3 -> IDLE next cycle, locked=0, err_count held; re-enable requires 1+4 strobes to lock.
REQ-041 Alternating half-periods 3/5 for 300 bad strobes -> err_count saturates at 255, no wrap.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared state encoding and default constants for the divided-clock
//            monitor.
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;

    localparam int c_def_expected_half = 4;
    localparam int c_def_tol           = 0;
    localparam int c_def_lock_count    = 4;
    localparam int c_def_cnt_w         = 8;

endpackage
`default_nettype wire

// File: rtl/clk_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : clk_edge_sync
// Brief    : Two-flop synchronizer plus previous-value flop; registered
//            one-cycle rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module clk_edge_sync (
    input  logic clk_hf,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise_q,  rise_d;
    logic fall_q,  fall_d;
    logic w_edge;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        w_edge  = sync2_q ^ prev_q;
        // Strobe lands on the third edge counting the one that first samples the new level.
        rise_d  = w_edge &  sync2_q;
        fall_d  = w_edge & ~sync2_q;
    end

    always_ff @(posedge clk_hf) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_monitor
// Brief    : Measures divided-clock half-periods, tracks lock and counts
//            bad periods / timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int EXPECTED_HALF = c_def_expected_half,
    parameter int TOL           = c_def_tol,
    parameter int LOCK_COUNT    = c_def_lock_count,
    parameter int CNT_W         = c_def_cnt_w
) (
    input  logic             clk_hf,
    input  logic             reset,
    input  logic             clk_div_in,
    input  logic             enable,
    output logic             rise_strobe,
    output logic             fall_strobe,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] half_period,
    output logic [7:0]       err_count
);

    localparam int c_gr_w = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W:0]    c_lo      = (CNT_W+1)'((EXPECTED_HALF > TOL) ? (EXPECTED_HALF - TOL) : 0);
    localparam logic [CNT_W:0]    c_hi      = (CNT_W+1)'(EXPECTED_HALF + TOL);
    localparam logic [CNT_W-1:0]  c_timeout = CNT_W'(EXPECTED_HALF + TOL);
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};
    localparam logic [c_gr_w-1:0] c_lock    = c_gr_w'(LOCK_COUNT);

    state_e              state_q,       state_d;
    logic [CNT_W-1:0]    half_cnt_q,    half_cnt_d;
    logic [CNT_W-1:0]    half_period_q, half_period_d;
    logic [c_gr_w-1:0]   good_run_q,    good_run_d;
    logic [7:0]          err_count_q,   err_count_d;
    logic                err_q,         err_d;
    logic                locked_q,      locked_d;

    logic                w_rise;
    logic                w_fall;
    logic                w_strobe;
    logic [CNT_W:0]      w_measured;
    logic                w_good;

    clk_edge_sync u_sync (
        .clk_hf (clk_hf),
        .reset  (reset),
        .d      (clk_div_in),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_strobe   = w_rise | w_fall;
    assign w_measured = {1'b0, half_cnt_q} + (CNT_W+1)'(1);
    assign w_good     = (w_measured >= c_lo) && (w_measured <= c_hi);

    always_comb begin
        state_d       = state_q;
        good_run_d    = good_run_q;
        half_period_d = half_period_q;
        err_count_d   = err_count_q;
        err_d         = 1'b0;
        half_cnt_d    = (half_cnt_q == c_cnt_max) ? half_cnt_q : half_cnt_q + CNT_W'(1);

        if (!enable) begin
            state_d    = ST_IDLE;
            good_run_d = '0;
            half_cnt_d = '0;
        end else begin
            if (w_strobe) begin
                half_cnt_d = '0;
                if (state_q != ST_IDLE) begin
                    // A saturated counter reports the largest representable period.
                    half_period_d = w_measured[CNT_W] ? c_cnt_max : w_measured[CNT_W-1:0];
                end
            end

            case (state_q)
                ST_IDLE: state_d = ST_SEARCH;
                ST_SEARCH: begin
                    if (w_strobe) begin
                        state_d    = ST_TRACK;
                        good_run_d = '0;
                    end
                end
                ST_TRACK, ST_LOCKED: begin
                    if (w_strobe) begin
                        if (!w_good) begin
                            state_d    = ST_TRACK;
                            good_run_d = '0;
                            err_d      = 1'b1;
                        end else if (state_q == ST_TRACK) begin
                            good_run_d = good_run_q + c_gr_w'(1);
                            if (good_run_d >= c_lock) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end else if (half_cnt_q >= c_timeout) begin
                        state_d    = ST_SEARCH;
                        good_run_d = '0;
                        err_d      = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_hf) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            half_cnt_q    <= '0;
            half_period_q <= '0;
            good_run_q    <= '0;
            err_count_q   <= '0;
            err_q         <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            half_cnt_q    <= half_cnt_d;
            half_period_q <= half_period_d;
            good_run_q    <= good_run_d;
            err_count_q   <= err_count_d;
            err_q         <= err_d;
            locked_q      <= locked_d;
        end
    end

    assign rise_strobe = w_rise;
    assign fall_strobe = w_fall;
    assign locked      = locked_q;
    assign err         = err_q;
    assign half_period = half_period_q;
    assign err_count   = err_count_q;

endmodule
`default_nettype wire
